// File: rtl/poly_pkg.sv
// Shared encodings for the polynomial RAM pass sequencer: operation modes,
// RAM select codes and sequencer FSM states.
package poly_pkg;

    typedef enum logic [1:0] {
        MODE_PWRITE = 2'b00,
        MODE_NTT    = 2'b01,
        MODE_INTT   = 2'b10,
        MODE_PWM    = 2'b11
    } mode_e;

    localparam logic [2:0] SEL_PWRITE = 3'b000;
    localparam logic [2:0] SEL_NTT    = 3'b001;
    localparam logic [2:0] SEL_INTT   = 3'b100;
    localparam logic [2:0] SEL_PWM    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [2:0] sel_code(input mode_e m);
        case (m)
            MODE_NTT:  sel_code = SEL_NTT;
            MODE_INTT: sel_code = SEL_INTT;
            MODE_PWM:  sel_code = SEL_PWM;
            default:   sel_code = SEL_PWRITE;
        endcase
    endfunction

endpackage

// File: rtl/wen_delay.sv
// One-bit delay line of depth LAT_MAX with a runtime tap; tap 0 passes the
// input straight through. Async clear on rst, sync clear on clr.
module wen_delay #(
    parameter int LAT_MAX = 11,
    parameter int TW      = $clog2(LAT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          din,
    input  logic [TW-1:0] tap,
    output logic          dout
);

    logic [LAT_MAX:1] sr;
    logic [LAT_MAX:0] taps;

    assign taps = {sr, din};
    assign dout = taps[tap];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     sr <= '0;
        else if (clr) sr <= '0;
        else          sr <= taps[LAT_MAX-1:0];
    end

endmodule

// File: rtl/poly_seq.sv
// Pass sequencer for the four-bank polynomial RAM (PWRITE/NTT/INTT/PWM).
// Optional feature: define POLY_SEQ_ABORT_EN to add the abort input.
module poly_seq
    import poly_pkg::*;
#(
    parameter int addr_width = 5,
    parameter int depth      = 32,
    parameter int NTT_PASSES = 4,
    parameter int BF_LAT     = 8,
    parameter int PWM_LAT    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
`ifdef POLY_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            sel,
    output logic                  wen,
    output logic [1:0]            bank0_index,
    output logic [1:0]            bank1_index,
    output logic [1:0]            bank2_index,
    output logic [1:0]            bank3_index,
    output logic [addr_width-1:0] addr0,
    output logic [addr_width-1:0] addr1,
    output logic [addr_width-1:0] addr2,
    output logic [addr_width-1:0] addr3
);

    localparam int LAT_MAX = (BF_LAT > PWM_LAT) ? BF_LAT : PWM_LAT;
    localparam int TW      = $clog2(LAT_MAX + 1);
    localparam int PW      = (NTT_PASSES > 4) ? $clog2(NTT_PASSES) : 2;

    state_e                state;
    logic [addr_width-1:0] cnt;
    logic [PW-1:0]         pass;
    logic [PW-1:0]         last_pass;
    logic [TW-1:0]         lat;
    logic [TW-1:0]         drain_cnt;
    logic                  issue;
    logic                  abort_hit;
    logic [addr_width-1:0] issue_addr;
    logic [3:0][1:0]       bidx;

    function automatic logic [TW-1:0] lat_of(input mode_e m);
        case (m)
            MODE_PWRITE: lat_of = '0;
            MODE_PWM:    lat_of = TW'(PWM_LAT);
            default:     lat_of = TW'(BF_LAT);
        endcase
    endfunction

    function automatic logic [addr_width-1:0] rotl(input logic [addr_width-1:0] c, input int r);
        logic [2*addr_width-1:0] d;
        d = {c, c} << r;
        return d[2*addr_width-1:addr_width];
    endfunction

`ifdef POLY_SEQ_ABORT_EN
    assign abort_hit = abort && (state == ST_READ || state == ST_DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    assign issue = (state == ST_READ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pass      <= '0;
            last_pass <= '0;
            lat       <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sel       <= SEL_PWRITE;
        end else if (abort_hit) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            sel   <= SEL_PWRITE;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_READ;
                        cnt       <= '0;
                        pass      <= '0;
                        drain_cnt <= '0;
                        lat       <= lat_of(mode_e'(mode));
                        last_pass <= (mode_e'(mode) == MODE_NTT || mode_e'(mode) == MODE_INTT)
                                     ? PW'(NTT_PASSES - 1) : '0;
                        sel       <= sel_code(mode_e'(mode));
                        busy      <= 1'b1;
                    end
                end
                ST_READ: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == addr_width'(depth - 1)) begin
                        drain_cnt <= '0;
                        if (lat != '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sel   <= SEL_PWRITE;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    // Next pass starts only once the last write-back has landed.
                    if (drain_cnt == lat - TW'(1)) begin
                        if (pass < last_pass) begin
                            pass  <= pass + 1'b1;
                            cnt   <= '0;
                            state <= ST_READ;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sel   <= SEL_PWRITE;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // pass stays 0 outside NTT/INTT, so the rotation is a no-op there.
    assign issue_addr = issue ? rotl(cnt, int'(pass) % addr_width) : '0;

    for (genvar k = 0; k < 4; k++) begin : g_bank
        assign bidx[k] = issue ? (2'(k) + pass[1:0]) : 2'b00;
    end

    assign bank0_index = bidx[0];
    assign bank1_index = bidx[1];
    assign bank2_index = bidx[2];
    assign bank3_index = bidx[3];
    assign addr0 = issue_addr;
    assign addr1 = issue_addr;
    assign addr2 = issue_addr;
    assign addr3 = issue_addr;

    // Held clear in IDLE so stale bits from a longer-latency op cannot leak
    // into the next operation's tap.
    wen_delay #(
        .LAT_MAX(LAT_MAX),
        .TW     (TW)
    ) u_wen_delay (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE || abort_hit),
        .din (issue),
        .tap (lat),
        .dout(wen)
    );

endmodule

// File: tb/tb_poly_seq.sv
// Directed self-checking bench for poly_seq (abort scenario built only when
// POLY_SEQ_ABORT_EN is defined).
module tb_poly_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
`ifdef POLY_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       busy, done, wen;
    logic [2:0] sel;
    logic [1:0] b0, b1, b2, b3;
    logic [4:0] a0, a1, a2, a3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    poly_seq dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef POLY_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .sel(sel), .wen(wen),
        .bank0_index(b0), .bank1_index(b1), .bank2_index(b2), .bank3_index(b3),
        .addr0(a0), .addr1(a1), .addr2(a2), .addr3(a3)
    );

    function automatic logic [7:0] bank_exp(input int p);
        logic [1:0] q;
        q = 2'(p);
        return {q + 2'd3, q + 2'd2, q + 2'd1, q};
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] v, input int r);
        int s;
        s = r % 5;
        return (v << s) | (v >> (5 - s));
    endfunction

    // start sampled at edge T0; returns just after T0, so the next negedge is cycle T0+1
    task automatic launch(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < limit);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, sel, wen, b3, b2, b1, b0, a3, a2, a1, a0} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {busy, done, sel, wen, b3, b2, b1, b0, a3, a2, a1, a0});
        end
        @(negedge clk) rst = 1'b1;
        launch(2'b01);
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_busy got=%b required=1", busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, sel, wen, b3, b2, b1, b0, a3, a2, a1, a0} !== 34'd0) begin
            failures++;
            $display("FAIL reset_midop got=%h required=0",
                     {busy, done, sel, wen, b3, b2, b1, b0, a3, a2, a1, a0});
        end
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, wen, sel} !== 6'd0) begin
                failures++;
                $display("FAIL reset_idle k=%0d busy/done/wen/sel got=%b required=0", k, {busy, done, wen, sel});
            end
        end
    endtask

    task automatic test_pwrite();
        launch(2'b00);
        for (int k = 1; k <= 33; k++) begin
            logic [5:0] exp_ctl;
            logic [4:0] exp_a;
            logic [7:0] exp_b;
            @(negedge clk);
            exp_ctl = (k <= 32) ? {1'b1, 1'b0, 1'b1, 3'b000} : {1'b0, 1'b1, 1'b0, 3'b000};
            exp_a   = (k <= 32) ? 5'(k - 1) : 5'd0;
            exp_b   = (k <= 32) ? bank_exp(0) : 8'd0;
            checks++;
            if ({busy, done, wen, sel} !== exp_ctl) begin
                failures++;
                $display("FAIL pwrite_ctl k=%0d busy/done/wen/sel got=%b required=%b", k, {busy, done, wen, sel}, exp_ctl);
            end
            checks++;
            if ({a3, a2, a1, a0} !== {4{exp_a}} || {b3, b2, b1, b0} !== exp_b) begin
                failures++;
                $display("FAIL pwrite_addr k=%0d addr=%h bank=%h required addr=%h bank=%h",
                         k, {a3, a2, a1, a0}, {b3, b2, b1, b0}, {4{exp_a}}, exp_b);
            end
        end
    endtask

    task automatic test_ntt();
        launch(2'b01);
        for (int k = 1; k <= 161; k++) begin
            int p, off;
            logic [5:0] exp_ctl;
            logic [4:0] exp_a;
            logic [7:0] exp_b;
            @(negedge clk);
            p   = (k - 1) / 40;
            off = (k - 1) % 40;
            if (k <= 160) exp_ctl = {1'b1, 1'b0, (off >= 8), 3'b001};
            else          exp_ctl = {1'b0, 1'b1, 1'b0, 3'b000};
            exp_a = (k <= 160 && off < 32) ? rotl5(5'(off), p) : 5'd0;
            exp_b = (k <= 160 && off < 32) ? bank_exp(p) : 8'd0;
            checks++;
            if ({busy, done, wen, sel} !== exp_ctl) begin
                failures++;
                $display("FAIL ntt_ctl k=%0d busy/done/wen/sel got=%b required=%b", k, {busy, done, wen, sel}, exp_ctl);
            end
            checks++;
            if ({a3, a2, a1, a0} !== {4{exp_a}} || {b3, b2, b1, b0} !== exp_b) begin
                failures++;
                $display("FAIL ntt_addr k=%0d addr=%h bank=%h required addr=%h bank=%h",
                         k, {a3, a2, a1, a0}, {b3, b2, b1, b0}, {4{exp_a}}, exp_b);
            end
            if (k == 84) begin
                checks++;
                if (a0 !== 5'd12 || b0 !== 2'd2) begin
                    failures++;
                    $display("FAIL ntt_pass2_cnt3 addr0=%0d bank0=%0d required 12 and 2", a0, b0);
                end
            end
            if (k == 9) begin
                checks++;
                if (wen !== 1'b1) begin
                    failures++;
                    $display("FAIL ntt_first_wen wen=%b required 1", wen);
                end
            end
        end
    endtask

    task automatic test_intt();
        int n;
        launch(2'b10);
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (sel !== 3'b100 || a0 !== 5'd0 || b0 !== 2'd0) begin
                    failures++;
                    $display("FAIL intt_first sel=%b addr0=%0d bank0=%0d required 100 0 0", sel, a0, b0);
                end
            end
            if (k == 42) begin
                checks++;
                if (a2 !== 5'd2 || b0 !== 2'd1 || b3 !== 2'd0) begin
                    failures++;
                    $display("FAIL intt_pass1 addr2=%0d bank0=%0d bank3=%0d required 2 1 0", a2, b0, b3);
                end
            end
        end
        wait_done("intt_done", 300, n);
        checks++;
        if (n !== 119) begin
            failures++;
            $display("FAIL intt_len done at k=%0d required 161", 42 + n);
        end
    endtask

    task automatic test_pwm();
        launch(2'b11);
        for (int k = 1; k <= 44; k++) begin
            logic [5:0] exp_ctl;
            logic [4:0] exp_a;
            @(negedge clk);
            if (k <= 43) exp_ctl = {1'b1, 1'b0, (k >= 12), 3'b010};
            else         exp_ctl = {1'b0, 1'b1, 1'b0, 3'b000};
            exp_a = (k <= 32) ? 5'(k - 1) : 5'd0;
            checks++;
            if ({busy, done, wen, sel} !== exp_ctl) begin
                failures++;
                $display("FAIL pwm_ctl k=%0d busy/done/wen/sel got=%b required=%b", k, {busy, done, wen, sel}, exp_ctl);
            end
            checks++;
            if ({a3, a2, a1, a0} !== {4{exp_a}} || {b3, b2, b1, b0} !== ((k <= 32) ? bank_exp(0) : 8'd0)) begin
                failures++;
                $display("FAIL pwm_addr k=%0d addr=%h bank=%h required addr=%h", k, {a3, a2, a1, a0}, {b3, b2, b1, b0}, {4{exp_a}});
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        launch(2'b00);
        for (int k = 1; k <= 36; k++) begin
            logic [5:0] exp_ctl;
            logic [4:0] exp_a;
            @(negedge clk);
            if (k <= 32)      exp_ctl = 6'b101000;
            else if (k == 33) exp_ctl = 6'b010000;
            else if (k == 34) exp_ctl = 6'b000000;
            else              exp_ctl = 6'b101000;
            exp_a = (k <= 32) ? 5'(k - 1) : (k >= 35) ? 5'(k - 35) : 5'd0;
            checks++;
            if ({busy, done, wen, sel} !== exp_ctl || a1 !== exp_a) begin
                failures++;
                $display("FAIL b2b k=%0d busy/done/wen/sel=%b addr1=%0d required %b %0d",
                         k, {busy, done, wen, sel}, a1, exp_ctl, exp_a);
            end
            // start with a different mode while busy and in DONE must be ignored
            start = (k == 5 || k == 33 || k == 34);
            mode  = (k == 5 || k == 33) ? 2'b01 : 2'b00;
        end
        start = 1'b0;
        wait_done("b2b_done", 100, n);
        checks++;
        if (n !== 31) begin
            failures++;
            $display("FAIL b2b_second_len done at k=%0d required 67", 36 + n);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_after busy/done=%b required 00", {busy, done});
        end
    endtask

`ifdef POLY_SEQ_ABORT_EN
    task automatic test_abort();
        int seen, n;
        launch(2'b01);
        for (int k = 1; k <= 76; k++) begin
            @(negedge clk);
            if (k == 75) begin
                checks++;
                if ({busy, wen, sel} !== 5'b11001) begin
                    failures++;
                    $display("FAIL abort_pre busy/wen/sel=%b required 11001", {busy, wen, sel});
                end
            end
            if (k == 76) begin
                checks++;
                if ({busy, done, wen, sel, a0} !== 11'd0) begin
                    failures++;
                    $display("FAIL abort_idle busy/done/wen/sel/addr0=%b required 0", {busy, done, wen, sel, a0});
                end
            end
            abort = (k == 75);
        end
        abort = 1'b0;
        seen = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (busy || done || wen) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_quiet active cycles=%0d required 0", seen);
        end
        launch(2'b00);
        wait_done("abort_pwrite", 100, n);
        checks++;
        if (n !== 33) begin
            failures++;
            $display("FAIL abort_pwrite_len done at k=%0d required 33", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pwrite();
        test_ntt();
        test_intt();
        test_pwm();
        test_back_to_back();
`ifdef POLY_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_seq.md
# poly_seq

Pass sequencer for the four-bank polynomial RAM. On a `start` it walks a fixed read/write schedule for one operation: plain write, NTT, INTT or PWM. Every cycle it drives the RAM's `sel`, `wen`, four bank indices and four addresses. It sits directly upstream of the banked polynomial memory and its butterfly data network, and replaces hand-driven address streams from the top-level controller.

## Interface
- `addr_width`, 5, bank address width
- `depth`, 32, words per bank; must equal 2**`addr_width`
- `NTT_PASSES`, 4, passes per NTT/INTT
- `BF_LAT`, 8, cycles from a read issue to its write-back in NTT/INTT
- `PWM_LAT`, 11, cycles from a read issue to its write-back in PWM
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  launch operation; sampled only in IDLE
- `mode`  in  2  operation code: 00 PWRITE, 01 NTT, 10 INTT, 11 PWM; sampled with `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `sel`  out  3  RAM mode: 000 PWRITE, 001 NTT, 100 INTT, 010 PWM
- `wen`  out  1  RAM write enable
- `bank0_index`..`bank3_index`  out  2 each  bank index per port
- `addr0`..`addr3`  out  `addr_width` each  address per port

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- `LAT` per mode: PWRITE 0, NTT/INTT `BF_LAT`, PWM `PWM_LAT`.
- `P` (pass count) per mode: `NTT_PASSES` for NTT/INTT, 1 otherwise.
- IDLE: with `start`=1, latch `mode`, clear `cnt` and `pass`, go to READ. Otherwise stay.
- READ: one issue per cycle.
  - Issue valid; `cnt` counts 0..`depth`-1.
  - At `cnt`=`depth`-1: go to DRAIN if `LAT`>0, else DONE.
- DRAIN: `drain_cnt` counts `LAT` cycles.
  - On the last DRAIN cycle: if `pass`<`P`-1, increment `pass`, clear `cnt` and go to READ; else go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Passes never overlap. The next pass's first read follows the previous pass's last write, so no RAW hazard.
- Bank indices on an issue cycle: `bank`k`_index` = (k + `pass`) mod 4.
- Addresses on an issue cycle:
  - PWRITE/PWM: all four `addr`k = `cnt`.
  - NTT/INTT: all four `addr`k = `cnt` rotated left by (`pass` mod `addr_width`).
- Addresses and indices are 0 on non-issue cycles.
- `wen` is the issue-valid flag delayed by `LAT` cycles through a shift register. In PWRITE, `wen` equals issue-valid, with no delay.
- `sel` is held at the latched mode code in READ and DRAIN. It is 000 in IDLE and DONE.
- `busy` is 1 in READ and DRAIN only.
- `start` while `busy` is ignored, and so is `start` in DONE.
- `mode` changes are ignored after latching.

## Timing
- Reset (async, `rst`=0): FSM to IDLE; all counters and the `wen` shift register cleared. All outputs are 0: `busy`, `done`, `sel`, `wen`, indices and addresses.
- Reset mid-operation aborts immediately. No `done` is produced and no further `wen`.
- `start` sampled at edge T0 → first issue in cycle T0+1. `busy` is high from T0+1.
- Busy duration = `P`·(`depth`+`LAT`) cycles. `done` follows in the next cycle with `busy`=0.
- The last `wen` pulse of a pass coincides with the last DRAIN cycle of that pass, or with the last READ cycle in PWRITE.
- A new `start` is accepted at the earliest in the cycle after `done`.

## Configuration
- `POLY_SEQ_ABORT_EN`
  - Defined: adds input `abort` (1 bit). `abort`=1 in READ or DRAIN returns the FSM to IDLE at the next edge and clears the `wen` shift register; no `done` is produced. `abort` has no effect in IDLE or DONE.
  - Undefined: the port does not exist, and only reset terminates an operation.

## Structure
- Shared package `poly_pkg`:
  - mode encodings
  - `sel` codes 000/001/100/010
  - FSM state typedef
- One sub-module, `wen_delay`: a parameterised 1-bit shift register of depth `LAT_MAX` with a runtime tap select and async clear. It is instantiated once and tapped at `LAT`.

## Test plan
- Reset: hold `rst`=0 during an NTT and release it. All outputs must read 0 and the FSM must be IDLE; a later `start` must run normally.
- PWRITE, `depth`=32: `start` at T0.
  - `wen`=1 in T0+1..T0+32, with `addr`k = 0..31 and `bank`k`_index` = k.
  - `done` at T0+33 with `busy`=0.
- NTT with defaults:
  - `busy` is high for 160 cycles and `done` comes at T0+161.
  - In pass 2, issue `cnt`=3 drives all `addr`k = 12 and `bank0_index`=2.
  - The first `wen` of pass 0 comes at T0+9.
- PWM:
  - `sel`=010 throughout, and `wen` high exactly in T0+12..T0+43.
  - `done` at T0+44.
- `start` asserted during `busy` and in the DONE cycle: neither may restart or extend the operation. A `start` one cycle after `done` is accepted.
- With `POLY_SEQ_ABORT_EN`: `abort` in DRAIN of an NTT pass 1.
  - IDLE next cycle, `wen` low from then on, and no `done`.
  - A following PWRITE completes normally.
